// File: rtl/elevator_ctrl_if.sv
// elevator_ctrl_if: call buttons in, car status and call lamps out
interface elevator_ctrl_if;
    logic [2:0] call;
    logic       moving;
    logic       f1;
    logic       f2;
    logic       f3;
    logic       up;
    logic [2:0] pending;
    modport master (output call, input moving, f1, f2, f3, up, pending);
    modport slave (input call, output moving, f1, f2, f3, up, pending);
endinterface

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: three-floor car controller that finishes its current direction before it reverses
module elevator_ctrl #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DWELL_CYCLES  = 3
) (
    input logic           clk,
    input logic           rst,
    elevator_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;
    localparam logic [7:0] TLAST = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DLAST = 8'(DWELL_CYCLES - 1);
    state_t     state, state_n;
    logic [1:0] pos, pos_n, npos;
    logic       up, up_n, moving, f1, f2, f3;
    logic [2:0] pend, pend_n, req, here, nhere, fwd, rev, beyond;
    logic [7:0] tcnt, tcnt_n, dcnt, dcnt_n;
    function automatic logic [2:0] above(input logic [1:0] p);
        return p == 2'd1 ? 3'b110 : p == 2'd2 ? 3'b100 : 3'b000;
    endfunction
    function automatic logic [2:0] below(input logic [1:0] p);
        return p == 2'd3 ? 3'b011 : p == 2'd2 ? 3'b001 : 3'b000;
    endfunction
    assign req    = pend | bus.call;
    assign here   = 3'b001 << (pos - 2'd1);
    assign npos   = (up && pos != 2'd3) ? pos + 2'd1 : (!up && pos != 2'd1) ? pos - 2'd1 : pos;
    assign nhere  = 3'b001 << (npos - 2'd1);
    assign fwd    = up ? above(pos) : below(pos);
    assign rev    = up ? below(pos) : above(pos);
    assign beyond = up ? above(npos) : below(npos);
    // Next-state decisions; every decision sees this cycle's calls merged with the latched lamps
    always_comb begin
        state_n = state;
        pos_n   = pos;
        up_n    = up;
        pend_n  = req;
        tcnt_n  = 8'd0;
        dcnt_n  = 8'd0;
        case (state)
            IDLE: begin
                if (|(req & here)) begin
                    state_n = DWELL;
                    pend_n  = req & ~here;
                end else if (|(req & fwd)) begin
                    state_n = MOVE;
                end else if (|(req & rev)) begin
                    state_n = MOVE;
                    up_n    = ~up;
                end
            end
            MOVE: begin
                if (tcnt == TLAST) begin
                    pos_n   = npos;
                    state_n = |(req & nhere) ? DWELL : |(req & beyond) ? MOVE : IDLE;
                    pend_n  = |(req & nhere) ? req & ~nhere : req;
                end else begin
                    tcnt_n = tcnt + 8'd1;
                end
            end
            default: begin
                pend_n  = req & ~here;
                dcnt_n  = |(req & here) ? 8'd0 : dcnt + 8'd1;
                state_n = (!(|(req & here)) && dcnt == DLAST) ? IDLE : DWELL;
            end
        endcase
    end
    // State, position and registered car status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pos    <= 2'd1;
            up     <= 1'b1;
            pend   <= 3'b000;
            tcnt   <= 8'd0;
            dcnt   <= 8'd0;
            moving <= 1'b0;
            f1     <= 1'b1;
            f2     <= 1'b0;
            f3     <= 1'b0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            up     <= up_n;
            pend   <= pend_n;
            tcnt   <= tcnt_n;
            dcnt   <= dcnt_n;
            moving <= state_n == MOVE;
            f1     <= pos_n == 2'd1 && state_n != MOVE;
            f2     <= pos_n == 2'd2 && state_n != MOVE;
            f3     <= pos_n == 2'd3 && state_n != MOVE;
        end
    end
    assign bus.moving  = moving;
    assign bus.f1      = f1;
    assign bus.f2      = f2;
    assign bus.f3      = f3;
    assign bus.up      = up;
    assign bus.pending = pend;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed scenarios plus random calls checked against a floor-level model
module tb_elevator_ctrl;
    localparam int TRAVEL = 4;
    localparam int DWELL  = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    elevator_ctrl_if bus();
    elevator_ctrl #(.TRAVEL_CYCLES(TRAVEL), .DWELL_CYCLES(DWELL)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // observed status packed as {moving, f1, f2, f3, up, pending[2:0]}
    wire [7:0] obs = {bus.moving, bus.f1, bus.f2, bus.f3, bus.up, bus.pending};
    // model: car is idle, travelling or dwelling, with a countdown of cycles left in that activity
    int m_floor = 1;
    int m_mode  = 0;
    int m_left  = 0;
    bit m_up    = 1'b1;
    bit m_pend [1:3];
    function automatic bit any_dir(int f, bit dir);
        for (int i = 1; i <= 3; i++) if (m_pend[i] && (dir ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic [7:0] exp_vec();
        return {m_mode == 1, m_floor == 1 && m_mode != 1, m_floor == 2 && m_mode != 1,
                m_floor == 3 && m_mode != 1, m_up, m_pend[3], m_pend[2], m_pend[1]};
    endfunction
    task automatic model_step(input logic [2:0] c, input logic r);
        if (r) begin
            m_floor = 1; m_up = 1'b1; m_mode = 0; m_left = 0;
            for (int i = 1; i <= 3; i++) m_pend[i] = 1'b0;
            return;
        end
        for (int i = 1; i <= 3; i++) m_pend[i] = m_pend[i] | c[i-1];
        if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_floor += m_up ? 1 : -1;
                if (m_pend[m_floor]) begin m_pend[m_floor] = 1'b0; m_mode = 2; m_left = DWELL; end
                else if (any_dir(m_floor, m_up)) m_left = TRAVEL;
                else m_mode = 0;
            end
        end else if (m_mode == 2) begin
            if (m_pend[m_floor]) begin m_pend[m_floor] = 1'b0; m_left = DWELL; end
            else begin m_left--; if (m_left == 0) m_mode = 0; end
        end else if (m_pend[m_floor]) begin
            m_pend[m_floor] = 1'b0; m_mode = 2; m_left = DWELL;
        end else if (any_dir(m_floor, m_up)) begin
            m_mode = 1; m_left = TRAVEL;
        end else if (any_dir(m_floor, !m_up)) begin
            m_mode = 1; m_left = TRAVEL; m_up = !m_up;
        end
    endtask
    task automatic tick(input logic [2:0] c, input logic r = 1'b0);
        bus.call = c;
        rst      = r;
        @(posedge clk);
        model_step(c, r);
        #1;
    endtask
    task automatic test_reset;
        tick(3'b111, 1'b1);
        tests++; if (obs !== 8'b0_100_1_000) begin fails++; $display("FAIL reset_state: got %b want 01001000", obs); end
        tests++; if (obs !== exp_vec()) begin fails++; $display("FAIL reset_model: got %b want %b", obs, exp_vec()); end
    endtask
    task automatic test_same_floor;
        tick(3'b000, 1'b1);
        tick(3'b001);
        tests++; if (obs !== 8'b0_100_1_000) begin fails++; $display("FAIL same_floor_e1: got %b want 01001000", obs); end
        tick(3'b010);
        tick(3'b000);
        tick(3'b000);
        tests++; if (obs !== 8'b0_100_1_010) begin fails++; $display("FAIL same_floor_dwell_hold: got %b want 01001010", obs); end
        tick(3'b000);
        tests++; if (obs !== 8'b1_000_1_010) begin fails++; $display("FAIL same_floor_e5_move: got %b want 10001010", obs); end
    endtask
    task automatic test_adjacent;
        tick(3'b000, 1'b1);
        tick(3'b010);
        tests++; if (obs !== 8'b1_000_1_010) begin fails++; $display("FAIL adjacent_e1: got %b want 10001010", obs); end
        repeat (3) tick(3'b000);
        tests++; if (obs !== 8'b1_000_1_010) begin fails++; $display("FAIL adjacent_e4: got %b want 10001010", obs); end
        tick(3'b000);
        tests++; if (obs !== 8'b0_010_1_000) begin fails++; $display("FAIL adjacent_e5_arrive: got %b want 00101000", obs); end
        tick(3'b001);
        tick(3'b000);
        tick(3'b000);
        tests++; if (obs !== 8'b0_010_1_001) begin fails++; $display("FAIL adjacent_e8_idle: got %b want 00101001", obs); end
        tick(3'b000);
        tests++; if (obs !== 8'b1_000_0_001) begin fails++; $display("FAIL adjacent_e9_reverse: got %b want 10000001", obs); end
    endtask
    task automatic test_pass_through;
        tick(3'b000, 1'b1);
        tick(3'b100);
        repeat (4) tick(3'b000);
        tests++; if (obs !== 8'b1_000_1_100) begin fails++; $display("FAIL pass_through_e5: got %b want 10001100", obs); end
        repeat (4) tick(3'b000);
        tests++; if (obs !== 8'b0_001_1_000) begin fails++; $display("FAIL pass_through_e9: got %b want 00011000", obs); end
    endtask
    task automatic test_direction;
        int  stops = 0;
        logic was_moving;
        tick(3'b000, 1'b1);
        tick(3'b010);
        tick(3'b101);
        tests++; if (obs !== 8'b1_000_1_111) begin fails++; $display("FAIL direction_latch: got %b want 10001111", obs); end
        was_moving = bus.moving;
        for (int i = 0; i < 40; i++) begin
            tick(3'b000);
            tests++; if (obs !== exp_vec()) begin fails++; $display("FAIL direction_model: cycle %0d got %b want %b", i, obs, exp_vec()); end
            if (was_moving && !bus.moving) stops = stops * 10 + (bus.f1 ? 1 : bus.f2 ? 2 : 3);
            was_moving = bus.moving;
        end
        tests++; if (stops !== 231) begin fails++; $display("FAIL direction_order: got %0d want 231", stops); end
        tests++; if (obs !== 8'b0_100_0_000) begin fails++; $display("FAIL direction_final: got %b want 01000000", obs); end
    endtask
    task automatic test_dwell_restart;
        tick(3'b000, 1'b1);
        tick(3'b001);
        tick(3'b000);
        tick(3'b001);
        tick(3'b010);
        tick(3'b000);
        tick(3'b000);
        tests++; if (obs !== 8'b0_100_1_010) begin fails++; $display("FAIL dwell_restart_hold: got %b want 01001010", obs); end
        tick(3'b000);
        tests++; if (obs !== 8'b1_000_1_010) begin fails++; $display("FAIL dwell_restart_move: got %b want 10001010", obs); end
    endtask
    task automatic test_reset_mid_move;
        tick(3'b000, 1'b1);
        tick(3'b100);
        tick(3'b000);
        tick(3'b000);
        tick(3'b010, 1'b1);
        tests++; if (obs !== 8'b0_100_1_000) begin fails++; $display("FAIL reset_mid_move: got %b want 01001000", obs); end
        repeat (8) tick(3'b000);
        tests++; if (obs !== 8'b0_100_1_000) begin fails++; $display("FAIL reset_no_motion: got %b want 01001000", obs); end
    endtask
    task automatic test_random;
        logic [2:0] c;
        logic       r;
        tick(3'b000, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            r = $urandom_range(0, 299) == 0;
            tick(c, r);
            tests++; if (obs !== exp_vec()) begin fails++; $display("FAIL random: cycle %0d call %b rst %b got %b want %b", i, c, r, obs, exp_vec()); end
        end
    endtask
    initial begin
        bus.call = 3'b000;
        test_reset;
        test_same_floor;
        test_adjacent;
        test_pass_through;
        test_direction;
        test_dwell_restart;
        test_reset_mid_move;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 4, clock cycles to move one floor (legal range 1..255).
REQ-002 SHALL have parameter DWELL_CYCLES, default 3, clock cycles held stopped at a serviced floor (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port call  input  3  floor request buttons; bit0 = floor 1, bit2 = floor 3; any-cycle pulse or level.
REQ-006 SHALL have port moving  output  1  car travelling between floors; feeds door_status moving.
REQ-007 SHALL have ports f1, f2, f3  output  1 each  car stopped at floor 1/2/3; feed door_status f1..f3.
REQ-008 SHALL have port up  output  1  travel direction, 1 = up, 0 = down.
REQ-009 SHALL have port pending  output  3  latched unserviced requests (call lamps), same bit order as call.

Function
REQ-010 SHALL implement FSM states IDLE, MOVE, DWELL; all outputs registered.
REQ-011 SHALL hold position register pos in {1,2,3}; fN = (pos==N) && !moving; exactly one fN high whenever moving=0, all fN low whenever moving=1.
REQ-012 SHALL use req = pending | call for all decisions in the same cycle; pending <= req with the serviced bit cleared.
REQ-013 IDLE: if req[pos] -> DWELL next edge, clear that bit; else if a request exists in current up direction -> MOVE keeping up; else if a request exists opposite -> MOVE with up inverted; else stay IDLE.
REQ-014 MOVE: moving=1; travel counter starts at 0 on entry and increments each cycle; on the edge where counter==TRAVEL_CYCLES-1, pos <= pos±1 and counter clears.
REQ-015 On arrival: if req[new pos] -> DWELL, moving=0, bit cleared; else if requests remain beyond new pos in direction up -> remain MOVE; else -> IDLE, moving=0.
REQ-016 DWELL: moving=0 for exactly DWELL_CYCLES cycles, then IDLE; a call to pos during DWELL is cleared immediately and restarts the dwell count.
REQ-017 Calls to floors other than pos SHALL only set pending bits, never alter an active MOVE or DWELL.
REQ-018 pos SHALL never leave 1..3; up forced 1 at floor 1 and 0 at floor 3 when a move starts.
REQ-019 Latency: call to current floor in IDLE -> DWELL on next edge; call to adjacent floor from IDLE -> arrival TRAVEL_CYCLES+1 edges after call asserted.
REQ-020 Simultaneous calls: all latched same cycle; service order follows REQ-013/REQ-015 (continue direction first).
REQ-021 Counters SHALL be 8 bits and never wrap during legal operation.

Reset
REQ-022 rst=1 at an edge SHALL force, on that edge: state IDLE, pos=1, pending=000, moving=0, up=1, f1=1, f2=0, f3=0, counters 0.
REQ-023 Reset mid-MOVE or mid-DWELL SHALL abandon the operation and drop all pending requests; calls during rst are ignored.

Verification
REQ-024 Reset check: assert rst one edge -> moving=0, f1=1, f2=f3=0, up=1, pending=000.
REQ-025 Same-floor call: IDLE at 1, call=001 one cycle at edge0 -> edge1 DWELL, f1=1, pending=000; edge4 IDLE.
REQ-026 Adjacent move (defaults): call=010 at edge0 -> edge1 moving=1, f1..f3=000, up=1; edge5 moving=0, f2=1; edge8 IDLE.
REQ-027 Pass-through: call=100 from floor 1 -> pos 2 at edge5 with moving still 1, f outputs 000; edge9 f3=1, moving=0.
REQ-028 Direction priority: at floor 2 heading up, pending=101 -> floor 3 served first, then up=0, floor 1 served; pending ends 000.
REQ-029 Reset mid-move: rst during MOVE counter==2 -> next edge pos=1, f1=1, moving=0, pending=000; no further motion.
